// File: rtl/nv_dw_minmax_pkg.sv
// Shared definitions for the NV_DW_minmax selector family: FSM encoding,
// mode constants and the lane-count to index-width helper.
package nv_dw_minmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } acc_state_e;

    localparam logic MINMAX_MIN = 1'b0;
    localparam logic MINMAX_MAX = 1'b1;

    // Same thresholds as the upstream selector so index widths always line up.
    function automatic int idx_width(input int lanes);
        if (lanes <= 2)       return 1;
        else if (lanes <= 4)  return 2;
        else if (lanes <= 8)  return 3;
        else if (lanes <= 16) return 4;
        else if (lanes <= 32) return 5;
        else                  return 6;
    endfunction

endpackage

// File: rtl/nv_dw_minmax_cmp.sv
// Compare/replace decision between the running winner and a candidate.
// Max mode lets the latest equal value win; min mode keeps the earliest.
module nv_dw_minmax_cmp
    import nv_dw_minmax_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] acc_value,
    input  logic [WIDTH-1:0] cand_value,
    output logic             replace
);

    always_comb begin
        replace = 1'b0;
        if (mode == MINMAX_MAX) begin
            replace = (cand_value >= acc_value);
        end else begin
            replace = (cand_value < acc_value);
        end
    end

endmodule

// File: rtl/nv_dw_minmax_acc.sv
// Folds per-beat NV_DW_minmax winners over a window into a running min/max
// and presents the window winner on a registered valid/ready output.
module nv_dw_minmax_acc
    import nv_dw_minmax_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    input  logic                   in_pvld,
    output logic                   in_prdy,
    input  logic [WIDTH-1:0]       in_value,
    input  logic [IDX_W-1:0]       in_index,
    input  logic                   in_last,
    input  logic                   cfg_min_max,
    output logic                   out_pvld,
    input  logic                   out_prdy,
    output logic [WIDTH-1:0]       out_value,
    output logic [CNT_W+IDX_W-1:0] out_index,
    output logic [CNT_W:0]         out_beats,
    output logic                   out_ovf
);

    localparam int OIDX_W = CNT_W + IDX_W;
    localparam logic [CNT_W-1:0] CNT_FULL = '1;

    acc_state_e state, state_nxt;

    logic [WIDTH-1:0]  acc_value, acc_value_nxt;
    logic [OIDX_W-1:0] acc_index, acc_index_nxt;
    logic [CNT_W:0]    beat_cnt, beat_cnt_nxt;
    logic              mode, mode_nxt;
    logic              close, close_ovf;
    logic              accept;
    logic              replace;
    logic              cnt_full;

    assign in_prdy  = (state != ST_HOLD);
    assign out_pvld = (state == ST_HOLD);
    assign accept   = in_pvld & in_prdy;
    assign cnt_full = (beat_cnt[CNT_W-1:0] == CNT_FULL);

    nv_dw_minmax_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .mode       (mode),
        .acc_value  (acc_value),
        .cand_value (in_value),
        .replace    (replace)
    );

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_value_nxt = acc_value;
        acc_index_nxt = acc_index;
        beat_cnt_nxt  = beat_cnt;
        mode_nxt      = mode;
        close         = 1'b0;
        close_ovf     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    acc_value_nxt = in_value;
                    acc_index_nxt = {{CNT_W{1'b0}}, in_index};
                    mode_nxt      = cfg_min_max;
                    beat_cnt_nxt  = (CNT_W+1)'(1);
                    if (in_last) begin
                        close     = 1'b1;
                        state_nxt = ST_HOLD;
                    end else begin
                        state_nxt = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                if (accept) begin
                    if (replace) begin
                        acc_value_nxt = in_value;
                        acc_index_nxt = {beat_cnt[CNT_W-1:0], in_index};
                    end
                    beat_cnt_nxt = beat_cnt + (CNT_W+1)'(1);
                    // A full counter closes the window even mid-stream; flag it.
                    if (in_last || cnt_full) begin
                        close     = 1'b1;
                        close_ovf = ~in_last;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_prdy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            acc_value <= '0;
            acc_index <= '0;
            beat_cnt  <= '0;
            mode      <= MINMAX_MIN;
        end else begin
            acc_value <= acc_value_nxt;
            acc_index <= acc_index_nxt;
            beat_cnt  <= beat_cnt_nxt;
            mode      <= mode_nxt;
        end
    end

    // Result registers load only on the closing beat, so they stay frozen in HOLD.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            out_value <= '0;
            out_index <= '0;
            out_beats <= '0;
            out_ovf   <= 1'b0;
        end else if (close) begin
            out_value <= acc_value_nxt;
            out_index <= acc_index_nxt;
            out_beats <= beat_cnt_nxt;
            out_ovf   <= close_ovf;
        end
    end

endmodule
